// File: rtl/execute_stage_if.sv
// execute_stage_if: bundles the ID/EX inputs, writeback forwarding inputs,
// branch redirect outputs and EX/MEM register outputs of the execute stage.
// The master modport drives the stage and the slave modport is the stage itself.
interface execute_stage_if #(parameter int DATA_WIDTH = 32);

    logic [2:0]            ALUctrlE;
    logic                  ALUSrcE;
    logic                  MemWriteE;
    logic [1:0]            ResultSrcE;
    logic                  BranchE;
    logic                  JumpE;
    logic                  branch_negE;
    logic                  PcOpE;
    logic                  RegWriteE;
    logic [DATA_WIDTH-1:0] ImmExtE;
    logic [DATA_WIDTH-1:0] rd1E;
    logic [DATA_WIDTH-1:0] rd2E;
    logic [DATA_WIDTH-1:0] pcE;
    logic [DATA_WIDTH-1:0] PCPlus4E;
    logic [2:0]            instr_14_12E;
    logic [4:0]            RdE;
    logic [4:0]            rs1E;
    logic [4:0]            rs2E;
    logic                  MulE;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [4:0]            RdW;
    logic                  RegWriteW;

    logic                  PCSrcE;
    logic [DATA_WIDTH-1:0] PCTargetE;
    logic                  StallMulE;
    logic                  RegWriteM;
    logic                  MemWriteM;
    logic [1:0]            ResultSrcM;
    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic [DATA_WIDTH-1:0] PCPlus4M;
    logic [4:0]            RdM;
    logic [2:0]            instr_14_12M;

    modport master (
        output ALUctrlE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
               branch_negE, PcOpE, RegWriteE, ImmExtE, rd1E, rd2E, pcE,
               PCPlus4E, instr_14_12E, RdE, rs1E, rs2E, MulE, ResultW, RdW,
               RegWriteW,
        input  PCSrcE, PCTargetE, StallMulE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM, instr_14_12M
    );

    modport slave (
        input  ALUctrlE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
               branch_negE, PcOpE, RegWriteE, ImmExtE, rd1E, rd2E, pcE,
               PCPlus4E, instr_14_12E, RdE, rs1E, rs2E, MulE, ResultW, RdW,
               RegWriteW,
        output PCSrcE, PCTargetE, StallMulE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM, instr_14_12M
    );

endinterface

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage with operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
// Optional feature macro: MULDIV_EN compiles in a 32-step shift-add multiplier
// that stalls the front of the pipe while a MUL is in flight.
module execute_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    execute_stage_if.slave bus
);

    logic                  reg_write_m;
    logic                  mem_write_m;
    logic [1:0]            result_src_m;
    logic [DATA_WIDTH-1:0] alu_result_m;
    logic [DATA_WIDTH-1:0] write_data_m;
    logic [DATA_WIDTH-1:0] pc_plus4_m;
    logic [4:0]            rd_m;
    logic [2:0]            funct3_m;

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] ex_result;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  zero;
    logic                  stall_mul;

    // Operand forwarding: the MEM-stage result wins over the WB-stage result
    always_comb begin
        fwd_a = bus.rd1E;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == bus.rs1E))
            fwd_a = alu_result_m;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.rs1E))
            fwd_a = bus.ResultW;

        fwd_b = bus.rd2E;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == bus.rs2E))
            fwd_b = alu_result_m;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.rs2E))
            fwd_b = bus.ResultW;
    end

    assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

    // ALU: arithmetic wraps modulo 2^32, shifts use the low five bits of SrcB
    always_comb begin
        alu_result = '0;
        case (bus.ALUctrlE)
            3'b000:  alu_result = fwd_a + src_b;
            3'b001:  alu_result = fwd_a - src_b;
            3'b010:  alu_result = fwd_a & src_b;
            3'b011:  alu_result = fwd_a | src_b;
            3'b100:  alu_result = fwd_a ^ src_b;
            3'b101:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
            3'b110:  alu_result = fwd_a << src_b[4:0];
            default: alu_result = fwd_a >> src_b[4:0];
        endcase
    end

    assign zero      = (alu_result == '0);
    assign jalr_sum  = fwd_a + bus.ImmExtE;

    assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & (zero ^ bus.branch_negE));
    assign bus.PCTargetE = bus.PcOpE ? {jalr_sum[DATA_WIDTH-1:1], 1'b0}
                                     : (bus.pcE + bus.ImmExtE);

`ifdef MULDIV_EN
    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t            mul_state;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [4:0]            count;
    logic                  done;

    // Iterative multiplier: latch operands on entry, then one shift-add per cycle for 32 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_state <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= 5'd0;
            done      <= 1'b0;
        end else begin
            case (mul_state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.MulE && !done) begin
                        mul_state <= BUSY;
                        mcand     <= fwd_a;
                        mplier    <= fwd_b;
                        acc       <= '0;
                        count     <= 5'd0;
                    end
                end
                BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        mul_state <= IDLE;
                        done      <= 1'b1;
                    end
                end
                default: mul_state <= IDLE;
            endcase
        end
    end

    assign stall_mul = bus.MulE & ~done;
    assign ex_result = bus.MulE ? acc : alu_result;
`else
    logic unused_mul_e;
    assign unused_mul_e = bus.MulE;
    assign stall_mul    = 1'b0;
    assign ex_result    = alu_result;
`endif

    assign bus.StallMulE = stall_mul;

    // EX/MEM register: bubble the controls while the multiplier holds the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
            rd_m         <= 5'd0;
            funct3_m     <= 3'd0;
        end else if (stall_mul) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            rd_m         <= 5'd0;
        end else begin
            reg_write_m  <= bus.RegWriteE;
            mem_write_m  <= bus.MemWriteE;
            result_src_m <= bus.ResultSrcE;
            alu_result_m <= ex_result;
            write_data_m <= fwd_b;
            pc_plus4_m   <= bus.PCPlus4E;
            rd_m         <= bus.RdE;
            funct3_m     <= bus.instr_14_12E;
        end
    end

    assign bus.RegWriteM    = reg_write_m;
    assign bus.MemWriteM    = mem_write_m;
    assign bus.ResultSrcM   = result_src_m;
    assign bus.ALUResultM   = alu_result_m;
    assign bus.WriteDataM   = write_data_m;
    assign bus.PCPlus4M     = pc_plus4_m;
    assign bus.RdM          = rd_m;
    assign bus.instr_14_12M = funct3_m;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later and registered outputs 1ns after the rising edge.
// The multiply checks are built only when MULDIV_EN is defined.
module tb_execute_stage;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    logic [2:0]  op_tab  [9];
    logic [31:0] a_tab   [9];
    logic [31:0] b_tab   [9];
    logic [31:0] exp_tab [9];

    execute_stage_if #(.DATA_WIDTH(32)) bus ();

    execute_stage #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Waits for the falling edge, puts a plain register-register/immediate op in E
    task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic alu_src);
        @(negedge clk);
        bus.ALUctrlE     = ctrl;
        bus.ALUSrcE      = alu_src;
        bus.MemWriteE    = 1'b0;
        bus.ResultSrcE   = 2'b00;
        bus.BranchE      = 1'b0;
        bus.JumpE        = 1'b0;
        bus.branch_negE  = 1'b0;
        bus.PcOpE        = 1'b0;
        bus.RegWriteE    = 1'b0;
        bus.ImmExtE      = imm;
        bus.rd1E         = a;
        bus.rd2E         = b;
        bus.pcE          = 32'd0;
        bus.PCPlus4E     = 32'd0;
        bus.instr_14_12E = 3'd0;
        bus.RdE          = 5'd0;
        bus.rs1E         = 5'd0;
        bus.rs2E         = 5'd0;
        bus.MulE         = 1'b0;
        bus.ResultW      = 32'd0;
        bus.RdW          = 5'd0;
        bus.RegWriteW    = 1'b0;
    endtask

`ifdef MULDIV_EN
    // Issues one MUL, checks 33 stall cycles with bubbles, then the product
    task automatic runMul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected, input string tag);
        int stall_high;
        int bubble_bad;
        applyStimulus(ADD, a, b, 32'd0, 1'b0);
        bus.MulE      = 1'b1;
        bus.RegWriteE = 1'b1;
        bus.RdE       = 5'd7;
        stall_high = 0;
        bubble_bad = 0;
        for (int i = 0; i < 33; i++) begin
            #1;
            if (bus.StallMulE === 1'b1) stall_high++;
            @(posedge clk);
            #1;
            if (bus.RegWriteM !== 1'b0) bubble_bad++;
            @(negedge clk);
        end
        checkOutput({tag, "_stall_cycles"}, 32'(stall_high), 32'd33);
        checkOutput({tag, "_bubbles"}, 32'(bubble_bad), 32'd0);
        #1;
        checkOutput({tag, "_stall_released"}, 32'(bus.StallMulE), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_product"}, bus.ALUResultM, expected);
        checkOutput({tag, "_regwrite"}, 32'(bus.RegWriteM), 32'd1);
        checkOutput({tag, "_rd"}, 32'(bus.RdM), 32'd7);
    endtask
`endif

    // Directed test sequence
    initial begin
        tests    = 0;
        failures = 0;

        op_tab[0] = SUB;    a_tab[0] = 32'd5;        b_tab[0] = 32'd7;        exp_tab[0] = 32'hFFFF_FFFE;
        op_tab[1] = 3'b010; a_tab[1] = 32'h0000_F0F0; b_tab[1] = 32'h0000_FF00; exp_tab[1] = 32'h0000_F000;
        op_tab[2] = 3'b011; a_tab[2] = 32'h0000_F0F0; b_tab[2] = 32'h0000_0F00; exp_tab[2] = 32'h0000_FFF0;
        op_tab[3] = 3'b100; a_tab[3] = 32'h0000_00FF; b_tab[3] = 32'h0000_000F; exp_tab[3] = 32'h0000_00F0;
        op_tab[4] = 3'b101; a_tab[4] = 32'hFFFF_FFFF; b_tab[4] = 32'd1;        exp_tab[4] = 32'd1;
        op_tab[5] = 3'b101; a_tab[5] = 32'd1;        b_tab[5] = 32'hFFFF_FFFF; exp_tab[5] = 32'd0;
        op_tab[6] = 3'b110; a_tab[6] = 32'd1;        b_tab[6] = 32'h0000_0024; exp_tab[6] = 32'h0000_0010;
        op_tab[7] = 3'b111; a_tab[7] = 32'h8000_0000; b_tab[7] = 32'd31;       exp_tab[7] = 32'd1;
        op_tab[8] = ADD;    a_tab[8] = 32'hFFFF_FFFF; b_tab[8] = 32'd2;        exp_tab[8] = 32'd1;

        rst = 1'b1;
        applyStimulus(ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_regwrite",  32'(bus.RegWriteM), 32'd0);
        checkOutput("reset_memwrite",  32'(bus.MemWriteM), 32'd0);
        checkOutput("reset_aluresult", bus.ALUResultM, 32'd0);
        checkOutput("reset_rd",        32'(bus.RdM), 32'd0);
        checkOutput("reset_stall",     32'(bus.StallMulE), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority on A: MEM beats WB, WB used when RdM is x0
        applyStimulus(ADD, 32'h11, 32'd0, 32'd0, 1'b0);
        bus.RdE = 5'd5;  bus.RegWriteE = 1'b1;
        @(posedge clk); #1;
        checkOutput("fwd_setup_alu", bus.ALUResultM, 32'h11);

        applyStimulus(ADD, 32'h99, 32'd0, 32'h100, 1'b1);
        bus.rs1E = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'h22;
        bus.PcOpE = 1'b1; bus.RegWriteE = 1'b1; bus.RdE = 5'd0;
        #1;
        checkOutput("fwd_a_mem_target", bus.PCTargetE, 32'h110);
        @(posedge clk); #1;
        checkOutput("fwd_a_mem_alu", bus.ALUResultM, 32'h111);

        applyStimulus(ADD, 32'h99, 32'd0, 32'h100, 1'b1);
        bus.rs1E = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'h22;
        bus.PcOpE = 1'b1;
        #1;
        checkOutput("fwd_a_wb_target", bus.PCTargetE, 32'h122);
        @(posedge clk); #1;
        checkOutput("fwd_a_wb_alu", bus.ALUResultM, 32'h122);

        // Forwarding on B into WriteDataM
        applyStimulus(ADD, 32'd0, 32'h77, 32'd0, 1'b1);
        bus.rs2E = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'h22;
        bus.MemWriteE = 1'b1;
        @(posedge clk); #1;
        checkOutput("fwd_b_wb", bus.WriteDataM, 32'h22);
        checkOutput("memwrite_m", 32'(bus.MemWriteM), 32'd1);

        applyStimulus(ADD, 32'd0, 32'h77, 32'd0, 1'b1);
        bus.rs2E = 5'd5; bus.RegWriteW = 1'b0; bus.RdW = 5'd5; bus.ResultW = 32'h22;
        @(posedge clk); #1;
        checkOutput("fwd_b_none", bus.WriteDataM, 32'h77);

        applyStimulus(ADD, 32'h44, 32'd0, 32'd0, 1'b0);
        bus.RdE = 5'd6; bus.RegWriteE = 1'b1;
        @(posedge clk);
        applyStimulus(ADD, 32'd0, 32'h77, 32'd0, 1'b1);
        bus.rs2E = 5'd6;
        @(posedge clk); #1;
        checkOutput("fwd_b_mem", bus.WriteDataM, 32'h44);

        // ALU operations with hand-computed results
        for (int i = 0; i < 9; i++) begin
            applyStimulus(op_tab[i], a_tab[i], b_tab[i], 32'd0, 1'b0);
            bus.RdE = 5'd3; bus.RegWriteE = 1'b1;
            @(posedge clk); #1;
            checkOutput($sformatf("alu_vec%0d", i), bus.ALUResultM, exp_tab[i]);
        end

        // Branch resolution
        applyStimulus(SUB, 32'd3, 32'd4, 32'h20, 1'b0);
        bus.BranchE = 1'b1; bus.branch_negE = 1'b1; bus.pcE = 32'h100;
        #1;
        checkOutput("bne_taken", 32'(bus.PCSrcE), 32'd1);
        checkOutput("bne_target", bus.PCTargetE, 32'h120);

        applyStimulus(SUB, 32'd4, 32'd4, 32'h20, 1'b0);
        bus.BranchE = 1'b1; bus.branch_negE = 1'b1; bus.pcE = 32'h100;
        #1;
        checkOutput("bne_not_taken", 32'(bus.PCSrcE), 32'd0);

        applyStimulus(SUB, 32'd4, 32'd4, 32'h20, 1'b0);
        bus.BranchE = 1'b1; bus.pcE = 32'h100;
        #1;
        checkOutput("beq_taken", 32'(bus.PCSrcE), 32'd1);

        applyStimulus(SUB, 32'd3, 32'd4, 32'h20, 1'b0);
        bus.BranchE = 1'b1; bus.pcE = 32'h100;
        #1;
        checkOutput("beq_not_taken", 32'(bus.PCSrcE), 32'd0);

        applyStimulus(SUB, 32'd3, 32'd4, 32'h40, 1'b0);
        bus.JumpE = 1'b1; bus.pcE = 32'h200;
        #1;
        checkOutput("jal_taken", 32'(bus.PCSrcE), 32'd1);
        checkOutput("jal_target", bus.PCTargetE, 32'h240);

        // jalr: target has bit 0 cleared, link value latched in the EX/MEM register
        applyStimulus(ADD, 32'h1003, 32'd0, 32'd4, 1'b1);
        bus.JumpE = 1'b1; bus.PcOpE = 1'b1; bus.PCPlus4E = 32'h2004;
        bus.RegWriteE = 1'b1; bus.RdE = 5'd1; bus.ResultSrcE = 2'b10;
        bus.instr_14_12E = 3'b101;
        #1;
        checkOutput("jalr_taken", 32'(bus.PCSrcE), 32'd1);
        checkOutput("jalr_target", bus.PCTargetE, 32'h1006);
        @(posedge clk); #1;
        checkOutput("jalr_pcplus4", bus.PCPlus4M, 32'h2004);
        checkOutput("jalr_resultsrc", 32'(bus.ResultSrcM), 32'd2);
        checkOutput("jalr_funct3", 32'(bus.instr_14_12M), 32'd5);

`ifdef MULDIV_EN
        runMul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul_neg1x3");

        // Reset while the multiplier is busy aborts it at once
        applyStimulus(ADD, 32'd5, 32'd9, 32'd0, 1'b0);
        bus.MulE = 1'b1; bus.RegWriteE = 1'b1; bus.RdE = 5'd7;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.MulE = 1'b0; bus.RegWriteE = 1'b0; bus.RdE = 5'd0;
        #1;
        checkOutput("rstmul_stall", 32'(bus.StallMulE), 32'd0);
        checkOutput("rstmul_aluresult", bus.ALUResultM, 32'd0);
        checkOutput("rstmul_pcplus4", bus.PCPlus4M, 32'd0);
        checkOutput("rstmul_regwrite", 32'(bus.RegWriteM), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runMul(32'd7, 32'd6, 32'd42, "mul_7x6");
`else
        // MulE is ignored: the op executes as a plain add in one cycle
        applyStimulus(ADD, 32'd2, 32'd3, 32'd0, 1'b0);
        bus.MulE = 1'b1; bus.RegWriteE = 1'b1; bus.RdE = 5'd7;
        #1;
        checkOutput("nomul_stall_e", 32'(bus.StallMulE), 32'd0);
        @(posedge clk); #1;
        checkOutput("nomul_result", bus.ALUResultM, 32'd5);
        checkOutput("nomul_regwrite", 32'(bus.RegWriteM), 32'd1);
        checkOutput("nomul_stall_after", 32'(bus.StallMulE), 32'd0);
`endif

        applyStimulus(ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
